// File: rtl/count_gen.sv
// Up-counting beat generator with a prevcount companion, driven out over valid/ready.
// Define COUNT_GEN_ERR_INJ_EN to enable deliberate sequence corruption through err_inj.
module count_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned START = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             ready,
  input  logic             err_inj,
  output logic             valid,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] prevcount,
  output logic             wrap,
  output logic             busy,
  output logic             err_flag
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] PREV_V  = START_V - WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1    = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             errf_q, errf_d;
  logic             xfer;
  logic             inj;

`ifdef COUNT_GEN_ERR_INJ_EN
  assign inj = err_inj;
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign inj = 1'b0;
`endif

  // clear swallows a coincident handshake entirely, so the FSM holds as well
  assign xfer = valid_q & ready & ~clear;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = RUN;
      RUN:      if (stop)  state_d = xfer ? IDLE : STOPPING;
      STOPPING: if (xfer)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    prev_d  = prev_q;
    errf_d  = errf_q;
    if (clear) begin
      count_d = START_V;
      prev_d  = PREV_V;
      errf_d  = 1'b0;
    end else if (xfer) begin
      prev_d  = count_q;
      count_d = count_q + (inj ? WIDTH'(2) : WIDTH'(1));
      if (inj) errf_d = 1'b1;
    end
    wrap_d  = xfer && (count_q == ALL1);
    valid_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= START_V;
      prev_q  <= PREV_V;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      errf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      errf_q  <= errf_d;
    end
  end

  assign valid     = valid_q;
  assign count     = count_q;
  assign prevcount = prev_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
`ifdef COUNT_GEN_ERR_INJ_EN
  assign err_flag  = errf_q;
`else
  assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_count_gen.sv
// Directed plus randomized bench for count_gen against a behavioural beat model.
module tb_count_gen;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, ready = 1'b0, err_inj = 1'b0;
  logic valid, wrap, busy, err_flag;
  logic [W-1:0] count, prevcount;

  int n_chk = 0;
  int n_fail = 0;

  // model: beat values as plain integers, generator activity as two flags
  int m_cnt, m_prev, m_wrap_cnt;
  bit m_active, m_draining, m_wrap, m_err;

  count_gen #(.WIDTH(W), .START(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .ready(ready), .err_inj(err_inj), .valid(valid), .count(count),
    .prevcount(prevcount), .wrap(wrap), .busy(busy), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_prev = MASK; m_active = 0; m_draining = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit cl, input bit rd, input bit ei);
    bit hs;
    bit inj_on;
`ifdef COUNT_GEN_ERR_INJ_EN
    inj_on = 1;
`else
    inj_on = 0;
`endif
    hs = m_active && rd && !cl;
    m_wrap = hs && (m_cnt == MASK);
    if (cl) begin
      m_cnt = 0; m_prev = MASK; m_err = 0;
    end else if (hs) begin
      m_prev = m_cnt;
      m_cnt = (m_cnt + ((inj_on && ei) ? 2 : 1)) % (MASK + 1);
      if (inj_on && ei) m_err = 1;
    end
    if (!m_active) begin
      if (st) begin m_active = 1; m_draining = 0; end
    end else if (m_draining) begin
      if (hs) begin m_active = 0; m_draining = 0; end
    end else if (sp) begin
      if (hs) m_active = 0; else m_draining = 1;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".prev"},  32'(prevcount), 32'(m_prev));
    chk({tag, ".valid"}, 32'(valid), 32'(m_active));
    chk({tag, ".busy"},  32'(busy), 32'(m_active));
    chk({tag, ".wrap"},  32'(wrap), 32'(m_wrap));
    chk({tag, ".err"},   32'(err_flag), 32'(m_err));
  endtask

  task automatic step(input string tag, input bit st, input bit sp, input bit cl,
                      input bit rd, input bit ei);
    start = st; stop = sp; clear = cl; ready = rd; err_inj = ei;
    @(posedge clk);
    model_edge(st, sp, cl, rd, ei);
    #1;
    chk_all(tag);
    start = 0; stop = 0; clear = 0; err_inj = 0;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 40 && m_cnt != target; i++) step("run", 0, 0, 0, 1, 0);
    chk("run_to.reached", 32'(count), 32'(target));
  endtask

  initial begin
    int exp_cnt;
    bit exp_err;
    // reset then idle
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.prev_const", 32'(prevcount), 32'hF);
    rst_n = 1;
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0);

    // streaming across the wrap
    step("start", 1, 0, 0, 1, 0);
    chk("start.count0", 32'(count), 32'h0);
    m_wrap_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step("stream", 0, 0, 0, 1, 0);
      if (wrap) m_wrap_cnt++;
      chk("stream.seq", 32'(count), 32'((i + 1) % 16));
    end
    chk("stream.wrap_pulses", 32'(m_wrap_cnt), 32'd1);

    // backpressure at count 5
    run_to(5);
    for (int i = 0; i < 4; i++) begin
      step("stall", 0, 0, 0, 0, 0);
      chk("stall.count", 32'(count), 32'h5);
      chk("stall.prev", 32'(prevcount), 32'h4);
    end
    step("unstall", 0, 0, 0, 1, 0);
    chk("unstall.count", 32'(count), 32'h6);

    // stop while stalled at 9
    run_to(9);
    step("stop_stall", 0, 1, 0, 0, 0);
    chk("stopping.valid", 32'(valid), 32'h1);
    step("drain", 0, 0, 0, 1, 0);
    chk("drain.valid", 32'(valid), 32'h0);
    chk("drain.count", 32'(count), 32'hA);
    chk("drain.prev", 32'(prevcount), 32'h9);

    // clear at count C overrides the transfer
    step("restart", 1, 0, 0, 0, 0);
    run_to(12);
    step("clear", 0, 0, 1, 1, 0);
    chk("clear.count", 32'(count), 32'h0);
    chk("clear.prev", 32'(prevcount), 32'hF);

    // error injection on the beat carrying 3
    run_to(3);
    step("inject", 0, 0, 0, 1, 1);
`ifdef COUNT_GEN_ERR_INJ_EN
    exp_cnt = 5; exp_err = 1;
`else
    exp_cnt = 4; exp_err = 0;
`endif
    chk("inject.count", 32'(count), 32'(exp_cnt));
    chk("inject.prev", 32'(prevcount), 32'h3);
    chk("inject.err", 32'(err_flag), 32'(exp_err));

    // asynchronous reset in the middle of a cycle while running
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("async.valid", 32'(valid), 32'h0);
    chk("async.busy", 32'(busy), 32'h0);
    chk("async.count", 32'(count), 32'h0);
    chk("async.prev", 32'(prevcount), 32'hF);
    @(negedge clk);
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(3) == 0), ($urandom_range(7) == 0),
           ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           ($urandom_range(3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
